// File: rtl/note_seq_pkg.sv
// Shared types and helpers for the note-box playback sequencer.
package note_seq_pkg;

  typedef enum logic [1:0] {IDLE, ARM, NOTE, GAP} state_t;

  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] END_CODE = 4'hF;

  // Codes at or above num_notes are rests and light nothing.
  function automatic logic [15:0] code_to_hilight(input logic [CODE_W-1:0] code,
                                                  input int num_notes);
    if (int'(code) < num_notes) return 16'd1 << code;
    return 16'd0;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control/display bundle between the button logic, the sequencer and the graph/audio path.
// loop_en exists only when NOTE_SEQ_LOOP_EN is defined.
interface note_sequencer_if
  import note_seq_pkg::*;
#(
  parameter int NUM_NOTES = 8,
  parameter int SEQ_LEN   = 16
);
  localparam int AW = $clog2(SEQ_LEN);

  logic                  frame_tick;
  logic                  start;
  logic                  stop;
  logic                  seq_wr_en;
  logic [AW-1:0]         seq_wr_addr;
  logic [CODE_W-1:0]     seq_wr_code;
`ifdef NOTE_SEQ_LOOP_EN
  logic                  loop_en;
`endif
  logic [NUM_NOTES-1:0]  hilight_on;
  logic                  play_hilight;
  logic                  tone_en;
  logic [CODE_W-1:0]     tone_idx;
  logic                  busy;
  logic                  done;

  modport slave (
    input  frame_tick, start, stop, seq_wr_en, seq_wr_addr, seq_wr_code,
`ifdef NOTE_SEQ_LOOP_EN
    input  loop_en,
`endif
    output hilight_on, play_hilight, tone_en, tone_idx, busy, done
  );

  modport master (
    output frame_tick, start, stop, seq_wr_en, seq_wr_addr, seq_wr_code,
`ifdef NOTE_SEQ_LOOP_EN
    output loop_en,
`endif
    input  hilight_on, play_hilight, tone_en, tone_idx, busy, done
  );

endinterface

// File: rtl/note_seq_mem.sv
// Sequence register file: synchronous write, combinational reads, reset to END.
module note_seq_mem
  import note_seq_pkg::*;
#(
  parameter int SEQ_LEN = 16,
  parameter int AW      = $clog2(SEQ_LEN)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [CODE_W-1:0] wr_code_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [CODE_W-1:0] rd_code_o,
  output logic [CODE_W-1:0] head_code_o
);

  logic [CODE_W-1:0] mem_q [SEQ_LEN];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SEQ_LEN; i++) mem_q[i] <= END_CODE;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_code_i;
    end
  end

  assign rd_code_o   = mem_q[rd_addr_i];
  // Entry 0 is read separately so a looping sequence can restart without a bubble.
  assign head_code_o = mem_q[0];

endmodule

// File: rtl/note_sequencer.sv
// Note-box playback controller paced by frame_tick; one note per beat, blank gap between.
// Define NOTE_SEQ_LOOP_EN to add loop_en (repeat the sequence instead of finishing).
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int NUM_NOTES       = 8,
  parameter int SEQ_LEN         = 16,
  parameter int FRAMES_PER_BEAT = 15,
  parameter int GAP_FRAMES      = 2
) (
  input logic             clk,
  input logic             reset_n,
  note_sequencer_if.slave bus
);

  localparam int AW      = $clog2(SEQ_LEN);
  localparam int CNT_MAX = (FRAMES_PER_BEAT > GAP_FRAMES) ? FRAMES_PER_BEAT : GAP_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BEAT_LOAD = CNT_W'(FRAMES_PER_BEAT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_FRAMES - 1);
  localparam logic [AW-1:0]    LAST_PTR  = AW'(SEQ_LEN - 1);

  state_t               state_q;
  logic [AW-1:0]        ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_NOTES-1:0] hilight_q;
  logic                 tone_en_q;
  logic [CODE_W-1:0]    tone_idx_q;
  logic                 busy_q;
  logic                 done_q;

  logic [AW-1:0]        rd_addr;
  logic [CODE_W-1:0]    rd_code;
  logic [CODE_W-1:0]    head_code;
  logic                 loop_en_w;
  logic                 end_hit;
  logic                 fetch_finish;
  logic [AW-1:0]        fetch_addr_d;
  logic [CODE_W-1:0]    fetch_code_d;

`ifdef NOTE_SEQ_LOOP_EN
  assign loop_en_w = bus.loop_en;
`else
  assign loop_en_w = 1'b0;
`endif

  // From GAP the fetch looks one entry ahead; from ARM it reads the current entry.
  assign rd_addr = (state_q == GAP) ? ptr_q + 1'b1 : ptr_q;

  note_seq_mem #(.SEQ_LEN(SEQ_LEN), .AW(AW)) u_mem (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en_i     (bus.seq_wr_en && (state_q == IDLE)),
    .wr_addr_i   (bus.seq_wr_addr),
    .wr_code_i   (bus.seq_wr_code),
    .rd_addr_i   (rd_addr),
    .rd_code_o   (rd_code),
    .head_code_o (head_code)
  );

  always_comb begin
    end_hit      = ((state_q == GAP) && (ptr_q == LAST_PTR)) || (rd_code == END_CODE);
    // An END at entry 0 can never restart, which keeps an empty sequence from looping forever.
    fetch_finish = end_hit && !(loop_en_w && (head_code != END_CODE));
    fetch_addr_d = end_hit ? '0 : rd_addr;
    fetch_code_d = end_hit ? head_code : rd_code;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      hilight_q  <= '0;
      tone_en_q  <= 1'b0;
      tone_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ARM;
          end
        end
        default: begin
          if (bus.stop || (bus.frame_tick && !(state_q == NOTE) &&
                           !(state_q == GAP && cnt_q != '0) && fetch_finish)) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            hilight_q  <= '0;
            tone_en_q  <= 1'b0;
            tone_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= !bus.stop;
          end else if (bus.frame_tick) begin
            if (state_q == NOTE) begin
              if (cnt_q == '0) begin
                state_q   <= GAP;
                cnt_q     <= GAP_LOAD;
                hilight_q <= '0;
                tone_en_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end else if (state_q == GAP && cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              state_q    <= NOTE;
              ptr_q      <= fetch_addr_d;
              cnt_q      <= BEAT_LOAD;
              tone_idx_q <= fetch_code_d;
              hilight_q  <= NUM_NOTES'(code_to_hilight(fetch_code_d, NUM_NOTES));
              tone_en_q  <= (int'(fetch_code_d) < NUM_NOTES);
            end
          end
        end
      endcase
    end
  end

  assign bus.hilight_on   = hilight_q;
  assign bus.tone_en      = tone_en_q;
  assign bus.tone_idx     = tone_idx_q;
  assign bus.busy         = busy_q;
  assign bus.play_hilight = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: frame-count reference model plus directed and random playback.
module tb_note_sequencer;
  import note_seq_pkg::*;

  localparam int NN  = 8;
  localparam int SL  = 16;
  localparam int FPB = 15;
  localparam int GF  = 2;
  localparam int P   = FPB + GF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  note_sequencer_if #(.NUM_NOTES(NN), .SEQ_LEN(SL)) bus ();

  note_sequencer #(.NUM_NOTES(NN), .SEQ_LEN(SL), .FRAMES_PER_BEAT(FPB), .GAP_FRAMES(GF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: playback position measured in frame ticks since the first fetch.
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_k    = 0;
  logic [3:0] m_mem [SL];
  logic [3:0] m_notes [$];

  function automatic bit loop_in();
`ifdef NOTE_SEQ_LOOP_EN
    return bus.loop_en;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    for (int i = 0; i < SL; i++) m_mem[i] = 4'hF;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_k    = 0;
        for (int i = 0; i < SL; i++) m_mem[i] = 4'hF;
      end else begin
        m_done = 1'b0;
        if (!m_busy) begin
          if (bus.seq_wr_en) m_mem[bus.seq_wr_addr] = bus.seq_wr_code;
          if (bus.start && !bus.stop) begin
            m_busy = 1'b1;
            m_k    = -1;
            m_notes.delete();
            for (int i = 0; i < SL; i++) begin
              if (m_mem[i] == 4'hF) break;
              m_notes.push_back(m_mem[i]);
            end
          end
        end else if (bus.stop) begin
          m_busy = 1'b0;
        end else if (bus.frame_tick) begin
          m_k++;
          if ((m_k % P == 0) && (m_k / P == m_notes.size())) begin
            if (loop_in() && m_notes.size() > 0) m_k = 0;
            else begin
              m_busy = 1'b0;
              m_done = 1'b1;
            end
          end
        end
      end
    end
  end

  function automatic void model_out(output logic [NN-1:0] hl, output logic ten,
                                    output logic [3:0] idx, output logic bsy);
    int j;
    int r;
    logic [3:0] c;
    hl  = '0;
    ten = 1'b0;
    idx = '0;
    bsy = m_busy;
    if (m_busy && m_k >= 0) begin
      j   = m_k / P;
      r   = m_k % P;
      c   = m_notes[j];
      idx = c;
      if (r < FPB && c < NN) begin
        hl  = NN'(1) << c;
        ten = 1'b1;
      end
    end
  endfunction

  // Every-cycle compare against the model.
  initial begin
    logic [NN-1:0] e_hl;
    logic e_ten, e_bsy;
    logic [3:0] e_idx;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        model_out(e_hl, e_ten, e_idx, e_bsy);
        check("hilight_on", 32'(bus.hilight_on), 32'(e_hl));
        check("tone_en", 32'(bus.tone_en), 32'(e_ten));
        check("tone_idx", 32'(bus.tone_idx), 32'(e_idx));
        check("busy", 32'(bus.busy), 32'(e_bsy));
        check("play_hilight", 32'(bus.play_hilight), 32'(e_bsy));
        check("done", 32'(bus.done), 32'(m_done));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_tick();
    step(); bus.frame_tick = 1'b1;
    step(); bus.frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    step(); bus.start = 1'b1;
    step(); bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_stop();
    step(); bus.stop = 1'b1;
    step(); bus.stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input int addr, input logic [3:0] code);
    step();
    bus.seq_wr_en   = 1'b1;
    bus.seq_wr_addr = 4'(addr);
    bus.seq_wr_code = code;
    step();
    bus.seq_wr_en   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hl"}, 32'(bus.hilight_on), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_tone_en"}, 32'(bus.tone_en), 32'd0);
    check({tag, "_tone_idx"}, 32'(bus.tone_idx), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_play"}, 32'(bus.play_hilight), 32'd0);
  endtask

  logic [NN-1:0] hl_tr [64];
  logic          done_tr [64];
  logic          busy_tr [64];
  logic          ten_tr [64];

  task automatic record_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_tick();
      hl_tr[i]   = bus.hilight_on;
      done_tr[i] = bus.done;
      busy_tr[i] = bus.busy;
      ten_tr[i]  = bus.tone_en;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int cnt_a, cnt_b, cnt_d, budget, len;
    bus.frame_tick  = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.seq_wr_en   = 1'b0;
    bus.seq_wr_addr = '0;
    bus.seq_wr_code = '0;
`ifdef NOTE_SEQ_LOOP_EN
    bus.loop_en     = 1'b0;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    step(); reset_n = 1'b1;

    // Two notes then END.
    wr(0, 4'd2); wr(1, 4'd5); wr(2, 4'hF);
    pulse_start();
    check("arm_busy", 32'(bus.busy), 32'd1);
    check("arm_hl", 32'(bus.hilight_on), 32'd0);
    record_ticks(40);
    cnt_a = 0; cnt_b = 0; cnt_d = 0;
    for (int i = 0; i < 40; i++) begin
      if (hl_tr[i] == 8'b0000_0100) cnt_a++;
      if (hl_tr[i] == 8'b0010_0000) cnt_b++;
      if (done_tr[i]) cnt_d++;
    end
    check("seq_first_hl", 32'(hl_tr[0]), 32'h04);
    check("seq_hold_end", 32'(hl_tr[14]), 32'h04);
    check("seq_gap1", 32'(hl_tr[15]), 32'h00);
    check("seq_gap2", 32'(hl_tr[16]), 32'h00);
    check("seq_second_hl", 32'(hl_tr[17]), 32'h20);
    check("seq_second_end", 32'(hl_tr[31]), 32'h20);
    check("seq_cnt_note2", 32'(cnt_a), 32'd15);
    check("seq_cnt_note5", 32'(cnt_b), 32'd15);
    check("seq_busy_33", 32'(busy_tr[33]), 32'd1);
    check("seq_done_34", 32'(done_tr[34]), 32'd1);
    check("seq_busy_34", 32'(busy_tr[34]), 32'd0);
    check("seq_done_count", 32'(cnt_d), 32'd1);

    // Rest entry then END.
    wr(0, 4'd9); wr(1, 4'hF);
    pulse_start();
    record_ticks(20);
    cnt_a = 0;
    for (int i = 0; i < 17; i++) if (hl_tr[i] != '0 || ten_tr[i]) cnt_a++;
    check("rest_quiet", 32'(cnt_a), 32'd0);
    check("rest_busy_16", 32'(busy_tr[16]), 32'd1);
    check("rest_done_17", 32'(done_tr[17]), 32'd1);
    check("rest_busy_17", 32'(busy_tr[17]), 32'd0);

    // Stop mid-note.
    wr(0, 4'd1); wr(1, 4'd3); wr(2, 4'd6); wr(3, 4'hF);
    pulse_start();
    record_ticks(5);
    check("stop_pre_hl", 32'(bus.hilight_on), 32'h02);
    pulse_stop();
    check("stop_busy", 32'(bus.busy), 32'd0);
    check("stop_hl", 32'(bus.hilight_on), 32'd0);
    check("stop_done", 32'(bus.done), 32'd0);
    repeat (4) @(posedge clk);

    // Write during playback is ignored; start+stop in IDLE does nothing.
    pulse_start();
    record_ticks(3);
    wr(0, 4'd7);
    pulse_stop();
    pulse_start();
    pulse_tick();
    check("replay_hl", 32'(bus.hilight_on), 32'h02);
    pulse_stop();
    step(); bus.start = 1'b1; bus.stop = 1'b1;
    step(); bus.start = 1'b0; bus.stop = 1'b0;
    @(negedge clk);
    check("startstop_busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-note.
    pulse_start();
    record_ticks(4);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    step(); reset_n = 1'b1;
    pulse_start();
    pulse_tick();
    check("rst_mem_done", 32'(bus.done), 32'd1);
    check("rst_mem_busy", 32'(bus.busy), 32'd0);

`ifdef NOTE_SEQ_LOOP_EN
    wr(0, 4'd1); wr(1, 4'hF);
    bus.loop_en = 1'b1;
    pulse_start();
    record_ticks(60);
    cnt_d = 0;
    for (int i = 0; i < 60; i++) if (done_tr[i]) cnt_d++;
    check("loop_hl_0", 32'(hl_tr[0]), 32'h02);
    check("loop_gap_15", 32'(hl_tr[15]), 32'h00);
    check("loop_hl_17", 32'(hl_tr[17]), 32'h02);
    check("loop_hl_34", 32'(hl_tr[34]), 32'h02);
    check("loop_no_done", 32'(cnt_d), 32'd0);
    step(); bus.loop_en = 1'b0;
    cnt_a = 0;
    while (!bus.done && cnt_a < 30) begin
      pulse_tick();
      cnt_a++;
    end
    check("loop_exit_ticks", 32'(cnt_a), 32'd9);
`endif

    // Randomised sequences.
    for (int s = 0; s < 6; s++) begin
      len = (s == 0) ? SL : $urandom_range(0, SL);
      for (int a = 0; a < SL; a++) begin
        if (a < len) wr(a, 4'($urandom_range(0, 14)));
        else if (a == len) wr(a, 4'hF);
      end
      repeat (2) pulse_tick();
      pulse_start();
      budget = 3000;
      while (bus.busy && budget > 0) begin
        budget--;
        case ($urandom_range(0, 99)) inside
          [0:84]: begin
            pulse_tick();
            repeat ($urandom_range(0, 2)) @(posedge clk);
          end
          [85:91]: wr($urandom_range(0, SL-1), 4'($urandom_range(0, 15)));
          [92:97]: pulse_start();
          default: if ($urandom_range(0, 9) == 0) pulse_stop();
        endcase
      end
      check("rand_idle", 32'(bus.busy), 32'd0);
      repeat (3) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
